// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared types and constants for the shared-multiplier scheduler.
//   state_e     - scheduler FSM states (idle, operand settle, response hold)
//   REQ0/REQ1   - requester identifiers, also used as grant / rsp_id encoding
//   Default*    - default operand width and settle-cycle count
//   CntWidth    - settle counter width; covers SETTLE_CYCLES up to 15
package mul_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StResp
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int unsigned DefaultWidth        = 32;
    localparam int unsigned DefaultSettleCycles = 2;
    localparam int unsigned CntWidth            = 4;

endpackage

// File: rtl/mul_sched_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
//   valid_i[1:0]  in  request valids, bit N belongs to requester N
//   last_grant_i  in  requester granted most recently
//   en_i          in  arbitration enabled this cycle
//   grant_o       out selected requester (REQ0 when nothing is valid)
//   any_valid_o   out enabled and at least one requester valid, i.e. a grant is real
module rr_arb2
    import mul_sched_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    input  logic       en_i,
    output logic       grant_o,
    output logic       any_valid_o
);

    always_comb begin
        grant_o = REQ0;
        case (valid_i)
            2'b01:   grant_o = REQ0;
            2'b10:   grant_o = REQ1;
            // Contention: hand the grant to whoever did not win last time.
            2'b11:   grant_o = ~last_grant_i;
            default: grant_o = REQ0;
        endcase
        any_valid_o = en_i & (|valid_i);
    end

endmodule

// File: rtl/mul_sched.sv
// mul_sched: shares one external combinational signed multiplier between two requesters.
// Operands are registered onto the multiplier and held SETTLE_CYCLES cycles (multicycle
// path), then the product is captured into HI/LO and returned over a valid/ready channel.
//   clk_i                  in  clock, rising edge
//   reset_ni               in  synchronous active-low reset
//   reqN_valid_i/_ready_o  in/out request handshake for requester N (N = 0, 1)
//   reqN_a_i, reqN_b_i     in  multiplier / multiplicand operands
//   mul_mplr_o, mul_mcnd_o out registered operands to the multiplier
//   mul_y_i                in  multiplier product
//   rsp_valid_o/_ready_i   out/in response handshake
//   rsp_id_o               out requester owning the product
//   rsp_hi_o, rsp_lo_o     out product upper / lower halves (architectural HI/LO)
//   busy_o                 out scheduler not idle
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int unsigned WIDTH         = DefaultWidth,
    parameter int unsigned SETTLE_CYCLES = DefaultSettleCycles
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               req0_valid_i,
    output logic               req0_ready_o,
    input  logic [WIDTH-1:0]   req0_a_i,
    input  logic [WIDTH-1:0]   req0_b_i,
    input  logic               req1_valid_i,
    output logic               req1_ready_o,
    input  logic [WIDTH-1:0]   req1_a_i,
    input  logic [WIDTH-1:0]   req1_b_i,
    output logic [WIDTH-1:0]   mul_mplr_o,
    output logic [WIDTH-1:0]   mul_mcnd_o,
    input  logic [2*WIDTH-1:0] mul_y_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic               rsp_id_o,
    output logic [WIDTH-1:0]   rsp_hi_o,
    output logic [WIDTH-1:0]   rsp_lo_o,
    output logic               busy_o
);

    localparam logic [CntWidth-1:0] SettleLoad = CntWidth'(SETTLE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                last_grant_q, last_grant_d;
    logic [WIDTH-1:0]    mplr_q, mplr_d;
    logic [WIDTH-1:0]    mcnd_q, mcnd_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;

    logic arb_en;
    logic grant;
    logic any_valid;

    // Readies are gated by reset so nothing looks accepted while reset is held.
    assign arb_en = reset_ni && (state_q == StIdle);

    rr_arb2 u_arb (
        .valid_i      ({req1_valid_i, req0_valid_i}),
        .last_grant_i (last_grant_q),
        .en_i         (arb_en),
        .grant_o      (grant),
        .any_valid_o  (any_valid)
    );

    assign req0_ready_o = arb_en && (grant == REQ0);
    assign req1_ready_o = arb_en && (grant == REQ1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        mplr_d       = mplr_q;
        mcnd_d       = mcnd_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;

        case (state_q)
            StIdle: begin
                // any_valid implies the granted requester is valid: a handshake happens.
                if (any_valid) begin
                    mplr_d       = (grant == REQ1) ? req1_a_i : req0_a_i;
                    mcnd_d       = (grant == REQ1) ? req1_b_i : req0_b_i;
                    rsp_id_d     = grant;
                    last_grant_d = grant;
                    cnt_d        = SettleLoad;
                    state_d      = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntWidth'(1);
                end else begin
                    {hi_d, lo_d} = mul_y_i;
                    rsp_valid_d  = 1'b1;
                    state_d      = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_grant_q <= REQ1;
            mplr_q       <= '0;
            mcnd_q       <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= REQ0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            mplr_q       <= mplr_d;
            mcnd_q       <= mcnd_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign mul_mplr_o  = mplr_q;
    assign mul_mcnd_o  = mcnd_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_hi_o    = hi_q;
    assign rsp_lo_o    = lo_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: doc/mul_sched.md
Name: mul_sched

Overview:
- Shares one combinational 32x32 signed multiplier (Mplr, Mcnd -> 64-bit Y) between two requesters: req0, the CPU control unit for the MUL instruction, and req1, an auxiliary/debug port.
- Registers the selected operands onto the multiplier inputs and holds them for a fixed number of settle cycles, so the slow array path is a multicycle path.
- Captures the 64-bit product into HI/LO registers and returns it to the requester over a valid/ready response channel.
- Only one transaction is in flight at a time.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- SETTLE_CYCLES, 2, cycles operands are held on the multiplier before capture; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a  in  WIDTH  requester 0 multiplier operand.
- req0_b  in  WIDTH  requester 0 multiplicand operand.
- req1_valid / req1_ready / req1_a / req1_b  same as req0, for requester 1.
- mul_mplr  out  WIDTH  to multiplier Mplr.
- mul_mcnd  out  WIDTH  to multiplier Mcnd.
- mul_y  in  2*WIDTH  from multiplier Y.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer takes product.
- rsp_id  out  1  requester that owns the product.
- rsp_hi  out  WIDTH  product[2W-1:W] (HI).
- rsp_lo  out  WIDTH  product[W-1:0] (LO).
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE, cnt=0, last_grant=1 (req0 wins first arbitration).
  - mul_mplr, mul_mcnd, rsp_hi, rsp_lo = 0; rsp_valid=0; rsp_id=0; busy=0.
  - req0_ready and req1_ready are forced to 0 while reset=0.
- Reset mid-operation: aborts immediately. No response is produced and the product is discarded. The requester must re-issue.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - reqN_ready = (state==IDLE) && grant==N, combinational.
  - Arbitration:
    - Only one valid: that requester is granted.
    - Both valid: grant = ~last_grant (round-robin).
  - On handshake (valid && ready) at edge T:
    - mul_mplr <= a, mul_mcnd <= b, rsp_id <= N, last_grant <= N.
    - cnt <= SETTLE_CYCLES-1, state <= SETTLE.
- SETTLE:
  - Operands are held stable.
  - If cnt != 0: cnt decrements.
  - If cnt == 0: {rsp_hi, rsp_lo} <= mul_y, rsp_valid <= 1, state <= RESP.
  - Capture occurs at edge T+SETTLE_CYCLES; rsp_valid is visible after it.
- RESP:
  - rsp_valid, rsp_id, rsp_hi and rsp_lo are held stable until rsp_ready=1.
  - On that edge: rsp_valid <= 0, state <= IDLE.
  - No new request is accepted in the same cycle as the response handshake.
  - Minimum issue interval is SETTLE_CYCLES+2 cycles.
- After a response, rsp_hi and rsp_lo retain the last product (architectural HI/LO). mul_mplr and mul_mcnd retain the last operands.
- Arithmetic: the block does not interpret sign. Two's-complement signed multiplication is the multiplier's job. Operands are passed unmodified; the product is split exactly at bit WIDTH.
- A requester that drops valid without a handshake is ignored. Valid held across IDLE->busy periods is serviced when the block returns to IDLE.
- Starvation-free: with both requesters continuously valid, grants strictly alternate 0,1,0,1...

Decomposition:
- Shared package mul_sched_pkg holds:
  - state enum {IDLE, SETTLE, RESP};
  - localparam REQ0=1'b0, REQ1=1'b1;
  - default WIDTH and SETTLE_CYCLES constants.
- One sub-module, rr_arb2: two-input round-robin arbiter. Inputs are valid pair, last_grant and enable; outputs are grant and any_valid.
- The multiplier is instantiated by the parent, not inside mul_sched.

Test Plan:
- Hold reset=0 for 2 cycles with req0_valid=1 -> req0_ready=0, rsp_valid=0, rsp_hi=rsp_lo=0, busy=0. After release, req0 is accepted on the first edge.
- req0 with a=0x0000FF00, b=0x000FFF0F, SETTLE_CYCLES=2, rsp_ready=1 -> rsp_valid rises 2 edges after accept. rsp_hi=0x0000000F, rsp_lo=0xEF0FF100, rsp_id=0.
- req1 with a=0xFFFFFFFF, b=0x000FFF0F -> rsp_hi=0xFFFFFFFF, rsp_lo=0xFFF000F1, rsp_id=1. Sign passes through untouched.
- Both valid continuously for 4 transactions -> grant order 0,1,0,1. Each accept is at least SETTLE_CYCLES+2 cycles apart. No ready is asserted while busy=1.
- Hold rsp_ready=0 for 5 cycles in RESP while req0_valid=1 -> rsp outputs stable, req0_ready=0. Accept occurs only in the cycle after the response handshake.
- Assert reset=0 during SETTLE -> next cycle busy=0 and rsp_valid=0, and no response appears. A new request is then serviced normally.
